// File: rtl/cic_pkg.sv
// Shared CIC helpers: register-width functions and legal parameter ranges,
// used by both the interpolator and the decimator.
package cic_pkg;

    localparam int CIC_N_MIN      = 1;
    localparam int CIC_N_MAX      = 6;
    localparam int CIC_R_LOG2_MIN = 1;
    localparam int CIC_R_LOG2_MAX = 6;

    // Worst-case CIC gain is R^N, so the accumulators need N*log2(R) guard bits.
    function automatic int cic_acc_w(input int in_w, input int n, input int r_log2);
        return in_w + n * r_log2;
    endfunction

    // Interpolator gain is R^(N-1), one stage less than the accumulator growth.
    function automatic int cic_interp_out_w(input int in_w, input int n, input int r_log2);
        return in_w + (n - 1) * r_log2;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb stage with differential delay 1: y = x - x_prev, updated on enable.
// Combinational path from i_X to o_Y; the delay register loads only when i_EN is high.
module cic_comb_stage #(
    parameter int W = 20
) (
    input  logic         i_CLK,
    input  logic         i_RST,
    input  logic         i_EN,
    input  logic [W-1:0] i_X,
    output logic [W-1:0] o_Y
);

    logic [W-1:0] delay;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            delay <= '0;
        end else if (i_EN) begin
            delay <= i_X;
        end
    end

    assign o_Y = i_X - delay;

endmodule

// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator (R = 2^R_LOG2): comb at input rate, zero-stuff, integrate at output rate.
// First output one edge after accept; output stalls hold all state and drop o_READY.
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int N      = 2,
    parameter int R_LOG2 = 2
) (
    input  logic                                          i_CLK,
    input  logic                                          i_RST,
    input  logic [IN_W-1:0]                               i_DATA,
    input  logic                                          i_VALID,
    output logic                                          o_READY,
    output logic [cic_interp_out_w(IN_W, N, R_LOG2)-1:0]  o_DATA,
    output logic                                          o_VALID,
    input  logic                                          i_READY
);

    localparam int ACC_W = cic_acc_w(IN_W, N, R_LOG2);
    localparam int OUT_W = cic_interp_out_w(IN_W, N, R_LOG2);

    if (N < CIC_N_MIN || N > CIC_N_MAX ||
        R_LOG2 < CIC_R_LOG2_MIN || R_LOG2 > CIC_R_LOG2_MAX) begin : g_param_err
        $error("cic_interpolator: N or R_LOG2 out of supported range");
    end

    logic                       busy;
    logic [R_LOG2-1:0]          phase;
    logic                       last_phase;
    logic                       adv;
    logic                       accept;
    logic [ACC_W-1:0]           r_up;
    logic [ACC_W-1:0]           u;
    logic [N:0][ACC_W-1:0]      c;
    logic [N-1:0][ACC_W-1:0]    integ;
    logic [N-1:0][ACC_W-1:0]    integ_nxt;
    logic [ACC_W-1:0]           acc;

    assign last_phase = (phase == {R_LOG2{1'b1}});
    assign adv        = busy & (~o_VALID | i_READY);
    assign o_READY    = ~busy | (adv & last_phase);
    assign accept     = i_VALID & o_READY;

    assign c[0] = {{(ACC_W - IN_W){i_DATA[IN_W-1]}}, i_DATA};

    for (genvar j = 0; j < N; j++) begin : g_comb
        cic_comb_stage #(.W(ACC_W)) u_comb (
            .i_CLK (i_CLK),
            .i_RST (i_RST),
            .i_EN  (accept),
            .i_X   (c[j]),
            .o_Y   (c[j+1])
        );
    end

    // Zero-stuffing: the held comb output enters only on phase 0.
    assign u = (phase == '0) ? r_up : '0;

    // Ripple: each integrator adds the already-updated value of the one before it.
    always_comb begin
        acc       = u;
        integ_nxt = '0;
        for (int j = 0; j < N; j++) begin
            acc          = integ[j] + acc;
            integ_nxt[j] = acc;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            busy    <= 1'b0;
            phase   <= '0;
            r_up    <= '0;
            integ   <= '0;
            o_DATA  <= '0;
            o_VALID <= 1'b0;
        end else begin
            if (adv) begin
                integ   <= integ_nxt;
                o_DATA  <= integ_nxt[N-1][OUT_W-1:0];
                o_VALID <= 1'b1;
                phase   <= phase + 1'b1;
                if (last_phase) begin
                    busy <= 1'b0;
                end
            end else if (o_VALID && i_READY) begin
                o_VALID <= 1'b0;
            end
            // A same-cycle accept restarts the burst and overrides the wrap above.
            if (accept) begin
                r_up  <= c[N];
                phase <= '0;
                busy  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cic_interpolator.sv
// Bench for cic_interpolator: N=2 and N=3 instances, directed vectors, queue-based output checking.
module tb_cic_interpolator;

    localparam int R = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] a_dat = '0;
    logic        a_vld = 1'b0;
    logic        a_ordy;
    logic [17:0] a_odat;
    logic        a_ovld;
    logic        a_irdy = 1'b1;

    logic [15:0] b_dat = '0;
    logic        b_vld = 1'b0;
    logic        b_ordy;
    logic [19:0] b_odat;
    logic        b_ovld;
    logic        b_irdy = 1'b1;

    cic_interpolator #(.IN_W(16), .N(2), .R_LOG2(2)) dut_a (
        .i_CLK(clk), .i_RST(rst), .i_DATA(a_dat), .i_VALID(a_vld), .o_READY(a_ordy),
        .o_DATA(a_odat), .o_VALID(a_ovld), .i_READY(a_irdy)
    );

    cic_interpolator #(.IN_W(16), .N(3), .R_LOG2(2)) dut_b (
        .i_CLK(clk), .i_RST(rst), .i_DATA(b_dat), .i_VALID(b_vld), .o_READY(b_ordy),
        .o_DATA(b_odat), .o_VALID(b_ovld), .i_READY(b_irdy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int qa[$];
    int qb[$];
    int pop_a = 0;
    int pop_a_cyc[$];
    int acc_a = 0;
    bit rate_on = 1'b0;
    int last_acc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Output monitors: a transfer is visible at the negedge before the edge that completes it.
    always @(negedge clk) begin : mon_a
        int e;
        if (!rst && a_ovld && a_irdy) begin
            n_cmp++;
            if (qa.size() == 0) begin
                n_bad++;
                $display("FAIL out_a: got %0d, expected no output", int'($signed(a_odat)));
            end else begin
                e = qa.pop_front();
                if (int'($signed(a_odat)) != e) begin
                    n_bad++;
                    $display("FAIL out_a[%0d]: got %0d, expected %0d", pop_a, int'($signed(a_odat)), e);
                end
            end
            pop_a++;
            pop_a_cyc.push_back(cyc);
        end
        if (!rst && a_vld && a_ordy) begin
            acc_a++;
            if (rate_on) begin
                if (last_acc >= 0) begin
                    n_cmp++;
                    if (cyc - last_acc != R) begin
                        n_bad++;
                        $display("FAIL accept_interval: got %0d, expected %0d", cyc - last_acc, R);
                    end
                end
                last_acc = cyc;
            end
        end
    end

    always @(negedge clk) begin : mon_b
        int e;
        if (!rst && b_ovld && b_irdy) begin
            n_cmp++;
            if (qb.size() == 0) begin
                n_bad++;
                $display("FAIL out_b: got %0d, expected no output", int'($signed(b_odat)));
            end else begin
                e = qb.pop_front();
                if (int'($signed(b_odat)) != e) begin
                    n_bad++;
                    $display("FAIL out_b: got %0d, expected %0d", int'($signed(b_odat)), e);
                end
            end
        end
    end

    // Drivers: called just after a posedge, return just after the accepting posedge.
    task automatic send_a(input int x, input int e0, input int e1, input int e2, input int e3);
        int t;
        qa.push_back(e0); qa.push_back(e1); qa.push_back(e2); qa.push_back(e3);
        a_dat = 16'(x);
        a_vld = 1'b1;
        t = 0;
        @(negedge clk);
        while (!a_ordy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("send_a_timeout", t, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_b(input int x, input int e0, input int e1, input int e2, input int e3);
        int t;
        qb.push_back(e0); qb.push_back(e1); qb.push_back(e2); qb.push_back(e3);
        b_dat = 16'(x);
        b_vld = 1'b1;
        t = 0;
        @(negedge clk);
        while (!b_ordy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("send_b_timeout", t, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((qa.size() != 0 || qb.size() != 0) && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (t >= 300) chk("drain_timeout", qa.size() + qb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int base;
        int acc0;
        int t;

        #1;
        chk("reset_o_valid", int'(a_ovld), 0);
        chk("reset_o_data", int'($signed(a_odat)), 0);
        chk("reset_o_ready", int'(a_ordy), 1);
        chk("reset_b_o_valid", int'(b_ovld), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Impulse, N=2: back-to-back inputs must give a gapless output stream.
        base = pop_a;
        send_a(1, 1, 2, 3, 4);
        send_a(0, 3, 2, 1, 0);
        send_a(0, 0, 0, 0, 0);
        a_vld = 1'b0;
        drain();
        chk("impulse_gapless",
            (pop_a_cyc.size() >= base + 12) ? pop_a_cyc[base+11] - pop_a_cyc[base] : -1, 11);

        // DC step, N=3: settles to 100 * R^2.
        send_b(100, 100, 300, 600, 1000);
        send_b(100, 1300, 1500, 1600, 1600);
        send_b(100, 1600, 1600, 1600, 1600);
        send_b(100, 1600, 1600, 1600, 1600);
        b_vld = 1'b0;
        drain();

        // Negative full-scale DC with i_VALID held high: also checks accept rate.
        base = pop_a;
        acc0 = acc_a;
        rate_on = 1'b1;
        last_acc = -1;
        send_a(-32768, -32768, -65536, -98304, -131072);
        for (int k = 0; k < 4; k++) send_a(-32768, -131072, -131072, -131072, -131072);
        a_vld = 1'b0;
        rate_on = 1'b0;
        drain();
        chk("rate_accepts", acc_a - acc0, 5);
        chk("rate_outputs", pop_a - base, 20);

        pulse_reset();

        // Backpressure: stall while the second output is presented.
        base = pop_a;
        fork
            begin
                send_a(1, 1, 2, 3, 4);
                send_a(0, 3, 2, 1, 0);
                a_vld = 1'b0;
            end
            begin
                t = 0;
                do begin
                    @(posedge clk);
                    t++;
                end while (pop_a != base + 1 && t < 200);
                if (t >= 200) chk("stall_wait_timeout", t, 0);
                #1 a_irdy = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("stall_o_data", int'($signed(a_odat)), 2);
                    chk("stall_o_ready", int'(a_ordy), 0);
                    chk("stall_o_valid", int'(a_ovld), 1);
                    @(posedge clk);
                    #1;
                end
                a_irdy = 1'b1;
            end
        join
        drain();
        chk("stall_outputs", pop_a - base, 8);

        // Reset mid-burst, then a clean impulse must follow.
        base = pop_a;
        send_a(1, 1, 2, 3, 4);
        a_vld = 1'b0;
        t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (pop_a != base + 2 && t < 200);
        if (t >= 200) chk("midburst_wait_timeout", t, 0);
        #2 rst = 1'b1;
        #1;
        chk("midreset_o_valid", int'(a_ovld), 0);
        chk("midreset_o_data", int'($signed(a_odat)), 0);
        chk("midreset_o_ready", int'(a_ordy), 1);
        qa.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        send_a(1, 1, 2, 3, 4);
        send_a(0, 3, 2, 1, 0);
        send_a(0, 0, 0, 0, 0);
        a_vld = 1'b0;
        drain();

        chk("queue_a_empty", qa.size(), 0);
        chk("queue_b_empty", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
